// File: rtl/spy_capture_bank.sv
// Spy capture bank: records the user-logic output word into a circular buffer once armed and
// freezes it a programmable number of samples after a trigger. Optional macro: SPY_TIMESTAMP_EN.
module spy_capture_bank #(
    parameter int unsigned DW         = 64,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned BW_ADDR    = 16,
    parameter int unsigned POST_DEF   = 512
) (
    input  logic               clk40,
    input  logic               m_aresetn,
    input  logic               cs,
    input  logic [1:0]         sel,
    input  logic [BW_ADDR-1:0] addr,
    input  logic [63:0]        r_in,
    input  logic               we,
    output logic [63:0]        r_out,
    input  logic [DW-1:0]      din,
    input  logic               din_valid,
    input  logic               trig_in,
    output logic               armed,
    output logic               done
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   trig_ptr_q, trig_ptr_d;
    logic                    wrapped_q, wrapped_d;
    logic [31:0]             post_len_q, post_len_d;
    logic [31:0]             post_cnt_q, post_cnt_d;
    logic [63:0]             r_out_q;
    logic                    armed_q, done_q;
    logic                    mem_we, trig_hit;
    logic [DW-1:0]           mem [Depth];

    logic reg_wr, ctrl_wr, arm, force_trig, clear, plen_wr, rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [63:0]           rd_data;
    logic [31:0]           ts_rd;

    assign rd_en      = cs & ~we;
    assign reg_wr     = cs & we & (sel == 2'd0);
    assign ctrl_wr    = reg_wr & (addr[2:0] == 3'd0);
    assign arm        = ctrl_wr & r_in[0];
    assign force_trig = ctrl_wr & r_in[1];
    assign clear      = ctrl_wr & r_in[2];
    assign plen_wr    = reg_wr & (addr[2:0] == 3'd3);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        wrapped_d  = wrapped_q;
        post_len_d = post_len_q;
        post_cnt_d = post_cnt_q;
        mem_we     = 1'b0;
        trig_hit   = 1'b0;
        if (clear) begin
            state_d   = StIdle;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
        end else if (arm) begin
            state_d   = StArmed;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
        end else begin
            unique case (state_q)
                StArmed: begin
                    if (din_valid) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                        if (&wr_ptr_q) wrapped_d = 1'b1;
                    end
                    if ((trig_in & din_valid) | force_trig) begin
                        trig_hit = 1'b1;
                        // A forced trigger without a sample points at the last sample written.
                        trig_ptr_d = din_valid ? wr_ptr_q : wr_ptr_q - DEPTH_LOG2'(1);
                        post_cnt_d = post_len_q;
                        state_d    = (post_len_q == 32'd0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (din_valid) begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(1);
                        post_cnt_d = post_cnt_q - 32'd1;
                        if (&wr_ptr_q) wrapped_d = 1'b1;
                        if (post_cnt_q == 32'd1) state_d = StDone;
                    end
                end
                StIdle, StDone: ;
            endcase
        end
        if (plen_wr) begin
            post_len_d = (r_in > 64'(Depth - 1)) ? 32'(Depth - 1) : r_in[31:0];
        end
    end

    always_ff @(posedge clk40 or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            wrapped_q  <= 1'b0;
            post_len_q <= 32'(POST_DEF);
            post_cnt_q <= '0;
            r_out_q    <= '0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            wrapped_q  <= wrapped_d;
            post_len_q <= post_len_d;
            post_cnt_q <= post_cnt_d;
            r_out_q    <= rd_en ? rd_data : 64'd0;
            armed_q    <= (state_d == StArmed) || (state_d == StPost);
            done_q     <= (state_d == StDone);
        end
    end

    always_ff @(posedge clk40) begin
        if (mem_we) mem[wr_ptr_q] <= din;
    end

`ifdef SPY_TIMESTAMP_EN
    logic [31:0] ts_q, ts_trig_q;

    always_ff @(posedge clk40 or negedge m_aresetn) begin
        if (!m_aresetn) begin
            ts_q      <= '0;
            ts_trig_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (trig_hit) ts_trig_q <= ts_q;
        end
    end

    assign ts_rd = ts_trig_q;
`else
    logic unused_trig_hit;
    assign unused_trig_hit = trig_hit;
    assign ts_rd           = 32'd0;
`endif

    // Logical index 0 is always the oldest sample in the buffer.
    assign rd_idx = (wrapped_q ? wr_ptr_q : '0) + addr[DEPTH_LOG2-1:0];

    always_comb begin
        rd_data = 64'd0;
        if (sel == 2'd0) begin
            unique case (addr[2:0])
                3'd1:    rd_data = {32'd0, 16'(wr_ptr_q), 13'd0, wrapped_q, state_q};
                3'd2:    rd_data = 64'(trig_ptr_q);
                3'd3:    rd_data = 64'(post_len_q);
                3'd4:    rd_data = 64'(ts_rd);
                default: rd_data = 64'd0;
            endcase
        end else if (sel == 2'd1 && (state_q == StIdle || state_q == StDone)) begin
            rd_data = 64'(mem[rd_idx]);
        end
    end

    logic unused_addr;
    assign unused_addr = ^addr;

    assign r_out = r_out_q;
    assign armed = armed_q;
    assign done  = done_q;

endmodule

// File: tb/tb_spy_capture_bank.sv
// Directed bench for spy_capture_bank with a small buffer (16 words) and a queue scoreboard.
module tb_spy_capture_bank;

    localparam int DW = 16;

    logic        clk40 = 1'b0;
    logic        m_aresetn;
    logic        cs, we, din_valid, trig_in;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [63:0] r_in, r_out;
    logic [DW-1:0] din;
    logic        armed, done;

    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    always #5 clk40 = ~clk40;

    spy_capture_bank #(
        .DW(DW), .DEPTH_LOG2(4), .BW_ADDR(16), .POST_DEF(512)
    ) dut (
        .clk40(clk40), .m_aresetn(m_aresetn), .cs(cs), .sel(sel), .addr(addr),
        .r_in(r_in), .we(we), .r_out(r_out), .din(din), .din_valid(din_valid),
        .trig_in(trig_in), .armed(armed), .done(done)
    );

    function automatic logic [63:0] st(input int s, input int w, input int wp);
        return 64'(s) | (64'(w) << 2) | (64'(wp) << 16);
    endfunction

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [63:0] got);
        logic [63:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_chk++;
        assert (got === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, got, e);
        end
    endtask

    task automatic chk_now(input string tag, input logic [63:0] got, input logic [63:0] e);
        push_exp(tag, e);
        compare(got);
    endtask

    // All bus/sample tasks start and end on a falling edge.
    task automatic wr(input logic [1:0] s, input logic [15:0] a, input logic [63:0] d);
        cs = 1'b1; we = 1'b1; sel = s; addr = a; r_in = d;
        @(negedge clk40);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] s, input logic [15:0] a,
                      input logic [63:0] e);
        push_exp(tag, e);
        cs = 1'b1; we = 1'b0; sel = s; addr = a;
        @(negedge clk40);
        cs = 1'b0;
        compare(r_out);
    endtask

    task automatic smp(input logic [DW-1:0] d, input logic t);
        din = d; din_valid = 1'b1; trig_in = t;
        @(negedge clk40);
        din_valid = 1'b0; trig_in = 1'b0;
    endtask

    initial begin
        logic [63:0] ts;
        m_aresetn = 1'b0;
        cs = 1'b0; we = 1'b0; sel = 2'd0; addr = '0; r_in = '0;
        din = '0; din_valid = 1'b0; trig_in = 1'b0;
        repeat (2) @(negedge clk40);
        chk_now("rst_r_out", r_out, 64'd0);
        chk_now("rst_armed", 64'(armed), 64'd0);
        chk_now("rst_done", 64'(done), 64'd0);
        m_aresetn = 1'b1;
        rd("rst_status", 2'd0, 16'd1, 64'd0);
        rd("rst_post_len", 2'd0, 16'd3, 64'd512);
        @(negedge clk40);
        chk_now("idle_r_out_zero", r_out, 64'd0);
        rd("ctrl_reads_zero", 2'd0, 16'd0, 64'd0);

        // No wrap: trigger on sample 10, three post samples.
        wr(2'd0, 16'd3, 64'd3);
        wr(2'd0, 16'd0, 64'd1);
        rd("a_status_armed", 2'd0, 16'd1, st(1, 0, 0));
        for (int k = 1; k <= 20; k++) begin
            smp(16'(k), k == 10);
            chk_now($sformatf("a_done_k%0d", k), 64'(done), 64'(k >= 13));
        end
        rd("a_trig_ptr", 2'd0, 16'd2, 64'd9);
        rd("a_status_done", 2'd0, 16'd1, st(3, 0, 13));
        for (int i = 0; i <= 12; i++) rd($sformatf("a_buf%0d", i), 2'd1, 16'(i), 64'(i + 1));

        // Wrapped: trigger on sample 30 of 40.
        wr(2'd0, 16'd0, 64'd1);
        rd("b_status_armed", 2'd0, 16'd1, st(1, 0, 0));
        for (int k = 1; k <= 40; k++) begin
            smp(16'(k), k == 30);
            chk_now($sformatf("b_done_k%0d", k), 64'(done), 64'(k >= 33));
        end
        rd("b_status_done", 2'd0, 16'd1, st(3, 1, 1));
        rd("b_trig_ptr", 2'd0, 16'd2, 64'd13);
        rd("b_buf0", 2'd1, 16'd0, 64'd18);
        rd("b_buf1", 2'd1, 16'd1, 64'd19);
        rd("b_buf15", 2'd1, 16'd15, 64'd33);
        wr(2'd1, 16'd0, 64'hdead);
        rd("b_buf_write_ignored", 2'd1, 16'd0, 64'd18);

        // Zero post length: done on the trigger sample itself.
        wr(2'd0, 16'd3, 64'd0);
        wr(2'd0, 16'd0, 64'd1);
        for (int k = 1; k <= 5; k++) begin
            smp(16'(k), k == 5);
            chk_now($sformatf("c_done_k%0d", k), 64'(done), 64'(k == 5));
        end
        rd("c_trig_ptr", 2'd0, 16'd2, 64'd4);
        rd("c_status", 2'd0, 16'd1, st(3, 0, 5));
        wr(2'd0, 16'd3, 64'hFFFF);
        rd("c_post_len_clamp", 2'd0, 16'd3, 64'd15);

        // Forced trigger without a sample, reads blocked during POST, CLEAR beats ARM.
        wr(2'd0, 16'd3, 64'd3);
        wr(2'd0, 16'd0, 64'd1);
        for (int k = 1; k <= 3; k++) smp(16'(k), 1'b0);
        wr(2'd0, 16'd0, 64'd2);
        rd("d_status_post", 2'd0, 16'd1, st(2, 0, 3));
        rd("d_trig_ptr_force", 2'd0, 16'd2, 64'd2);
        rd("d_buf_in_post", 2'd1, 16'd0, 64'd0);
        chk_now("d_armed_post", 64'(armed), 64'd1);
        wr(2'd0, 16'd0, 64'd5);
        rd("d_status_clear", 2'd0, 16'd1, 64'd0);
        chk_now("d_armed_clear", 64'(armed), 64'd0);
        rd("d_ts_default", 2'd0, 16'd4, 64'd0);

        // Asynchronous reset in the middle of POST.
        wr(2'd0, 16'd0, 64'd1);
        smp(16'd7, 1'b1);
        chk_now("e_armed_post", 64'(armed), 64'd1);
        cs = 1'b1; we = 1'b0; sel = 2'd0; addr = 16'd1;
        @(posedge clk40);
        #2;
        chk_now("e_r_out_pre_rst", r_out, st(2, 0, 1));
        m_aresetn = 1'b0;
        #1;
        chk_now("e_rst_r_out", r_out, 64'd0);
        chk_now("e_rst_armed", 64'(armed), 64'd0);
        chk_now("e_rst_done", 64'(done), 64'd0);
        cs = 1'b0;
        @(negedge clk40);
        m_aresetn = 1'b1;
        rd("e_status_after", 2'd0, 16'd1, 64'd0);
        rd("e_post_len_after", 2'd0, 16'd3, 64'd512);

        // Forced trigger 100 cycles after reset with nothing captured.
        m_aresetn = 1'b0;
        @(negedge clk40);
        m_aresetn = 1'b1;
        wr(2'd0, 16'd0, 64'd1);
        repeat (99) @(negedge clk40);
        wr(2'd0, 16'd0, 64'd2);
        rd("f_trig_ptr_empty", 2'd0, 16'd2, 64'd15);
        rd("f_status", 2'd0, 16'd1, st(2, 0, 0));
`ifdef SPY_TIMESTAMP_EN
        push_exp("f_ts_window", 64'd1);
        cs = 1'b1; we = 1'b0; sel = 2'd0; addr = 16'd4;
        @(negedge clk40);
        cs = 1'b0;
        ts = r_out;
        compare(64'(ts >= 64'd99 && ts <= 64'd101));
`else
        ts = 64'd0;
        rd("f_ts_absent", 2'd0, 16'd4, ts);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spy_capture_bank.md
Name: spy_capture_bank

Overview:
- Responder on the core parallel register bus (cs/sel/addr/r_in/r_out/we) produced by the AXI-to-parallel decoder.
- Continuously records the user-logic output word into a circular buffer once armed, freezes it a programmable number of samples after a trigger, and serves control, status and buffer contents back to the bus.
- Complements injection: injection writes stimulus into the algorithm; this block reads the algorithm's response out.
- Bus and spy data share one clock domain; any crossing is done outside this block.

Parameters:
DW, 64, spy word width (1..64); stored word zero-extended to 64 on readout
DEPTH_LOG2, 10, buffer depth is 2**DEPTH_LOG2 words
BW_ADDR, 16, parallel bus address width
POST_DEF, 512, post-trigger sample count after reset

Ports:
clk40  input  1  single clock for bus and capture
m_aresetn  input  1  asynchronous active-low reset
cs  input  1  chip select for this block from decoder
sel  input  2  0 = register space, 1 = buffer space, 2/3 = unmapped
addr  input  BW_ADDR  word address within selected space
r_in  input  64  bus write data
we  input  1  write enable, qualified by cs
r_out  output  64  read data, zero when not selected (OR-mux compatible)
din  input  DW  spy data from user logic
din_valid  input  1  din sample strobe
trig_in  input  1  external trigger, sampled only with din_valid
armed  output  1  high in ARMED or POST
done  output  1  high in DONE

Behaviour:
- Reset, asynchronous, any state: FSM=IDLE, wr_ptr=0, wrapped=0, trig_ptr=0, post_len=POST_DEF, post_cnt=0, r_out=0, armed=0, done=0. Buffer RAM contents not reset.
- Register map, sel=0, addr[2:0]; other addr values read 0, writes ignored:
  - 0 CTRL, write-only, reads 0: bit0 ARM, bit1 FORCE_TRIG, bit2 CLEAR. Self-clearing strobes.
  - 1 STATUS: [1:0] state (IDLE=0, ARMED=1, POST=2, DONE=3), bit2 wrapped, [31:16] wr_ptr.
  - 2 TRIG_PTR: physical index of the trigger sample.
  - 3 POST_LEN: r/w; write value clamped to 2**DEPTH_LOG2-1.
  - 4 TIMESTAMP: see Optional Feature.
- FSM:
  - IDLE: no capture. ARM -> ARMED, with wr_ptr=0 and wrapped=0.
  - ARMED: each din_valid writes din at wr_ptr, then wr_ptr+1 mod depth. Wrap from max to 0 sets wrapped. Trigger = (trig_in & din_valid) | FORCE_TRIG.
    - On trigger with din_valid: the current sample is written, trig_ptr=its index, post_cnt=post_len, go POST; go DONE directly if post_len=0.
    - FORCE_TRIG without din_valid: trig_ptr=wr_ptr-1 mod depth, nothing written.
  - POST: each din_valid writes and decrements post_cnt. When the write that brings post_cnt to 0 completes -> DONE. Further triggers ignored.
  - DONE: writes frozen. ARM restarts capture exactly as from IDLE.
  - CLEAR, any state, has priority over ARM in the same write: -> IDLE, wr_ptr=0, wrapped=0. ARM while ARMED/POST restarts.
- Buffer read, sel=1:
  - Logical index i=addr[DEPTH_LOG2-1:0] maps to physical (start+i) mod depth.
  - start=wr_ptr if wrapped, else 0, so i=0 is always the oldest sample.
  - Reads in ARMED/POST return 0. Buffer space is read-only; writes ignored.
- Read latency: r_out valid 1 cycle after cs&!we; holds 0 on every cycle after a cycle without a read. Write takes effect on the cs&we edge; same-cycle read returns pre-write value.
- armed and done are registered decodes of the FSM state.

Optional Feature:
- Macro SPY_TIMESTAMP_EN.
- Defined: free-running 32-bit counter cleared by reset, wraps at 2**32. Its value is latched at the trigger cycle and read at addr 4.
- Undefined: no counter logic; addr 4 reads 0.

Test Plan:
- Reset with cs=0 -> r_out=0, STATUS reads 0, POST_LEN reads 512.
- DEPTH_LOG2=4, POST_LEN=3, ARM, din=1..20 continuous, trig_in with din=10 -> trig_ptr=9, DONE after din=13; buffer i=0..12 reads 1..13, wrapped=0.
- Same setup, trigger at din=30 of 40 -> wrapped=1, DONE after din=33; i=0 reads 18, i=15 reads 33.
- POST_LEN=0, trigger on din=5 -> DONE in the same sample, TRIG_PTR=4. Write POST_LEN=0xFFFF -> reads 15.
- During POST, write CTRL=0x5 (CLEAR+ARM) -> state IDLE, wr_ptr=0. Assert m_aresetn low mid-POST -> all outputs 0 immediately.
- With SPY_TIMESTAMP_EN, FORCE_TRIG 100 cycles after reset -> addr 4 reads 100±1 per documented latch cycle. Without the macro -> addr 4 reads 0.
